// File: rtl/alarm_controller.sv
// alarm_controller
// Alarm sequencer that sits downstream of count_time. It compares the live
// hours/minutes against the switch-set alarm time and runs an
// IDLE / ARMED / RINGING / SNOOZE state machine. It drives the 16 board LEDs:
// the MSB lights when armed, all LEDs flash while ringing, and LED0 is added
// while snoozing. Dismiss/snooze inputs are one-cycle debounced pulses.
// All outputs are registered and change on the same edge as the state.

module alarm_controller #(
    parameter int FLASH_DIV      = 12_500_000,
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300
) (
    input  logic        master_clock,
    input  logic        reset,
    input  logic        alarm_enable,
    input  logic [4:0]  alarm_hours,
    input  logic [5:0]  alarm_mins,
    input  logic [5:0]  hours_value,
    input  logic [5:0]  mins_value,
    input  logic        sec_tick,
    input  logic        dismiss,
    input  logic        snooze,
    output logic [15:0] led,
    output logic        ringing,
    output logic        snoozing
);

    // Counter widths are just wide enough to hold each parameter value.
    localparam int FW = $clog2(FLASH_DIV + 1);
    localparam int RW = $clog2(RING_TIMEOUT_S + 1);
    localparam int SW = $clog2(SNOOZE_S + 1);

    localparam logic [FW-1:0] FLASH_ZERO = FW'(0);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
    localparam logic [RW-1:0] RING_ZERO  = RW'(0);
    localparam logic [RW-1:0] RING_LAST  = RW'(RING_TIMEOUT_S - 1);
    localparam logic [SW-1:0] SNZ_ZERO   = SW'(0);
    localparam logic [SW-1:0] SNZ_ONE    = SW'(1);
    localparam logic [SW-1:0] SNZ_LOAD   = SW'(SNOOZE_S);

    // LED patterns for each state.
    localparam logic [15:0] LED_OFF    = 16'h0000;
    localparam logic [15:0] LED_ARMED  = 16'h8000;
    localparam logic [15:0] LED_ALL    = 16'hFFFF;
    localparam logic [15:0] LED_SNOOZE = 16'h8001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;

    // An alarm time outside 00:00..23:59 can never match, even if the
    // time inputs happen to carry the same out-of-range value.
    function automatic logic alarm_match(
        input logic [4:0] ah,
        input logic [5:0] am,
        input logic [5:0] hv,
        input logic [5:0] mv
    );
        logic in_range;
        in_range = (ah <= 5'd23) && (am <= 6'd59);
        return in_range && (hv == {1'b0, ah}) && (mv == am);
    endfunction

    state_t          state_q,     state_d;
    logic [15:0]     led_q,       led_d;
    logic            ringing_q,   ringing_d;
    logic            snoozing_q,  snoozing_d;
    logic            match_q,     match_d;
    logic [FW-1:0]   flash_cnt_q, flash_cnt_d;
    logic [RW-1:0]   ring_cnt_q,  ring_cnt_d;
    logic [SW-1:0]   snz_cnt_q,   snz_cnt_d;

    logic            match_s;
    logic            trigger_s;

    // Rising edge of the time match: one trigger per alarm minute at most.
    always_comb begin
        match_s   = alarm_match(alarm_hours, alarm_mins, hours_value, mins_value);
        trigger_s = match_s && !match_q;
        match_d   = match_s;
    end

    // Next-state, counter and LED computation for the alarm sequencer.
    always_comb begin
        state_d     = state_q;
        led_d       = led_q;
        flash_cnt_d = flash_cnt_q;
        ring_cnt_d  = ring_cnt_q;
        snz_cnt_d   = snz_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (alarm_enable) begin
                    state_d = ST_ARMED;
                    led_d   = LED_ARMED;
                end else begin
                    led_d   = LED_OFF;
                end
            end

            ST_ARMED: begin
                if (!alarm_enable) begin
                    state_d = ST_IDLE;
                    led_d   = LED_OFF;
                end else if (trigger_s) begin
                    state_d     = ST_RINGING;
                    led_d       = LED_ALL;
                    ring_cnt_d  = RING_ZERO;
                    flash_cnt_d = FLASH_ZERO;
                end else begin
                    led_d   = LED_ARMED;
                end
            end

            ST_RINGING: begin
                if (!alarm_enable) begin
                    state_d = ST_IDLE;
                    led_d   = LED_OFF;
                end else if (dismiss) begin
                    state_d = ST_ARMED;
                    led_d   = LED_ARMED;
                end else if (snooze) begin
                    state_d   = ST_SNOOZE;
                    led_d     = LED_SNOOZE;
                    snz_cnt_d = SNZ_LOAD;
                end else if (sec_tick && (ring_cnt_q == RING_LAST)) begin
                    // Unanswered ring: go quiet but stay armed.
                    state_d = ST_ARMED;
                    led_d   = LED_ARMED;
                end else begin
                    // Keep ringing: flash the LEDs and count seconds.
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_cnt_d = FLASH_ZERO;
                        led_d       = ~led_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 1'b1;
                    end
                    if (sec_tick) begin
                        ring_cnt_d = ring_cnt_q + 1'b1;
                    end else begin
                        ring_cnt_d = ring_cnt_q;
                    end
                end
            end

            ST_SNOOZE: begin
                if (!alarm_enable) begin
                    state_d = ST_IDLE;
                    led_d   = LED_OFF;
                end else if (dismiss) begin
                    state_d = ST_ARMED;
                    led_d   = LED_ARMED;
                end else if (sec_tick && (snz_cnt_q == SNZ_ONE)) begin
                    // Snooze period over: ring again from the start.
                    state_d     = ST_RINGING;
                    led_d       = LED_ALL;
                    ring_cnt_d  = RING_ZERO;
                    flash_cnt_d = FLASH_ZERO;
                    snz_cnt_d   = SNZ_ZERO;
                end else if (sec_tick && (snz_cnt_q != SNZ_ZERO)) begin
                    snz_cnt_d = snz_cnt_q - 1'b1;
                    led_d     = LED_SNOOZE;
                end else begin
                    led_d     = LED_SNOOZE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                led_d   = LED_OFF;
            end
        endcase
    end

    // Status flags registered alongside the state so they change on the same edge.
    always_comb begin
        ringing_d  = (state_d == ST_RINGING);
        snoozing_d = (state_d == ST_SNOOZE);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            led_q       <= LED_OFF;
            ringing_q   <= 1'b0;
            snoozing_q  <= 1'b0;
            match_q     <= 1'b1;
            flash_cnt_q <= FLASH_ZERO;
            ring_cnt_q  <= RING_ZERO;
            snz_cnt_q   <= SNZ_ZERO;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            ringing_q   <= ringing_d;
            snoozing_q  <= snoozing_d;
            match_q     <= match_d;
            flash_cnt_q <= flash_cnt_d;
            ring_cnt_q  <= ring_cnt_d;
            snz_cnt_q   <= snz_cnt_d;
        end
    end

    assign led      = led_q;
    assign ringing  = ringing_q;
    assign snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Testbench for alarm_controller: directed scenarios with literal
// expectations, then randomized stimulus checked every cycle against a
// behavioural model of the alarm rules.

module tb_alarm_controller;

    localparam int FLASH_DIV      = 4;
    localparam int RING_TIMEOUT_S = 3;
    localparam int SNOOZE_S       = 2;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RING  = 2;
    localparam int M_SNZ   = 3;

    logic        master_clock = 1'b0;
    logic        reset        = 1'b1;
    logic        alarm_enable = 1'b0;
    logic [4:0]  alarm_hours  = 5'd7;
    logic [5:0]  alarm_mins   = 6'd30;
    logic [5:0]  hours_value  = 6'd7;
    logic [5:0]  mins_value   = 6'd30;
    logic        sec_tick     = 1'b0;
    logic        dismiss      = 1'b0;
    logic        snooze       = 1'b0;
    logic [15:0] led;
    logic        ringing;
    logic        snoozing;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    int m_state = M_IDLE;
    int m_age   = 0;   // cycles spent ringing since the ring started
    int m_secs  = 0;   // seconds spent ringing
    int m_snz   = 0;   // seconds of snooze left
    bit m_prev  = 1'b1;

    alarm_controller #(
        .FLASH_DIV     (FLASH_DIV),
        .RING_TIMEOUT_S(RING_TIMEOUT_S),
        .SNOOZE_S      (SNOOZE_S)
    ) dut (
        .master_clock(master_clock),
        .reset       (reset),
        .alarm_enable(alarm_enable),
        .alarm_hours (alarm_hours),
        .alarm_mins  (alarm_mins),
        .hours_value (hours_value),
        .mins_value  (mins_value),
        .sec_tick    (sec_tick),
        .dismiss     (dismiss),
        .snooze      (snooze),
        .led         (led),
        .ringing     (ringing),
        .snoozing    (snoozing)
    );

    always #5 master_clock = ~master_clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit time_matches();
        int ah, am, hv, mv;
        ah = alarm_hours; am = alarm_mins; hv = hours_value; mv = mins_value;
        return (ah < 24) && (am < 60) && (hv == ah) && (mv == am);
    endfunction

    function automatic logic [15:0] exp_led();
        case (m_state)
            M_ARMED: return 16'h8000;
            M_SNZ:   return 16'h8001;
            M_RING:  return (((m_age / FLASH_DIV) % 2) == 0) ? 16'hFFFF : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic start_ring();
        m_state = M_RING;
        m_age   = 0;
        m_secs  = 0;
    endtask

    // Model update from the inputs sampled at a rising edge.
    task automatic model_step();
        bit match, trig;
        match = time_matches();
        trig  = match && !m_prev;
        if (reset) begin
            m_state = M_IDLE;
            match   = 1'b1;
        end else if (m_state == M_IDLE) begin
            if (alarm_enable) m_state = M_ARMED;
        end else if (!alarm_enable) begin
            m_state = M_IDLE;
        end else if (m_state == M_ARMED) begin
            if (trig) start_ring();
        end else if (m_state == M_RING) begin
            if (dismiss) m_state = M_ARMED;
            else if (snooze) begin
                m_state = M_SNZ;
                m_snz   = SNOOZE_S;
            end else if (sec_tick && (m_secs + 1 == RING_TIMEOUT_S)) m_state = M_ARMED;
            else begin
                m_age++;
                if (sec_tick) m_secs++;
            end
        end else begin
            if (dismiss) m_state = M_ARMED;
            else if (sec_tick) begin
                m_snz--;
                if (m_snz == 0) start_ring();
            end
        end
        m_prev = match;
    endtask

    task automatic tick();
        @(posedge master_clock);
        model_step();
        @(negedge master_clock);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_tick();
        sec_tick = 1'b1; tick(); sec_tick = 1'b0;
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge master_clock) begin
        if (check_en) begin
            check("model_led",      led,               exp_led());
            check("model_ringing",  {15'd0, ringing},  {15'd0, (m_state == M_RING)});
            check("model_snoozing", {15'd0, snoozing}, {15'd0, (m_state == M_SNZ)});
        end
    end

    initial begin
        // Reset with the time equal to the alarm and alarm enabled.
        reset = 1'b1; alarm_enable = 1'b1;
        tick();
        check_en = 1'b1;
        tick();
        check("rst_led", led, 16'h0000);
        check("rst_ringing", {15'd0, ringing}, 16'd0);
        reset = 1'b0;
        tick();
        check("armed_led", led, 16'h8000);
        ticks(3);
        check("no_ring_in_reset_minute", {15'd0, ringing}, 16'd0);

        // 07:31 -> 07:30 triggers; LEDs toggle every FLASH_DIV cycles.
        mins_value = 6'd31; tick();
        mins_value = 6'd30; tick();
        check("ring_start", {15'd0, ringing}, 16'd1);
        check("ring_led_on", led, 16'hFFFF);
        ticks(3);
        check("ring_led_still_on", led, 16'hFFFF);
        tick();
        check("ring_led_off", led, 16'h0000);
        ticks(4);
        check("ring_led_on_again", led, 16'hFFFF);

        // Three seconds unanswered -> back to ARMED, no re-trigger at 07:30.
        pulse_tick(); tick(); pulse_tick();
        check("ring_before_timeout", {15'd0, ringing}, 16'd1);
        tick(); pulse_tick();
        check("timeout_led", led, 16'h8000);
        check("timeout_ringing", {15'd0, ringing}, 16'd0);
        ticks(5);
        check("stays_armed", led, 16'h8000);

        // 07:29 -> 07:30, snooze, two seconds, ring again.
        mins_value = 6'd29; tick();
        mins_value = 6'd30; tick();
        snooze = 1'b1; tick(); snooze = 1'b0;
        check("snooze_led", led, 16'h8001);
        check("snoozing", {15'd0, snoozing}, 16'd1);
        pulse_tick();
        check("still_snoozing", led, 16'h8001);
        pulse_tick();
        check("re_ring_led", led, 16'hFFFF);
        check("re_ring", {15'd0, ringing}, 16'd1);

        // Dismiss and snooze together: dismiss wins.
        dismiss = 1'b1; snooze = 1'b1; tick(); dismiss = 1'b0; snooze = 1'b0;
        check("dismiss_wins_led", led, 16'h8000);
        check("dismiss_wins_snz", {15'd0, snoozing}, 16'd0);

        // Disable while ringing -> IDLE.
        mins_value = 6'd29; tick();
        mins_value = 6'd30; tick();
        alarm_enable = 1'b0; tick();
        check("disable_led", led, 16'h0000);
        check("disable_ringing", {15'd0, ringing}, 16'd0);

        // Reset while snoozing -> everything clear.
        alarm_enable = 1'b1; tick();
        mins_value = 6'd29; tick();
        mins_value = 6'd30; tick();
        snooze = 1'b1; tick(); snooze = 1'b0;
        reset = 1'b1; tick();
        check("rst_snz_led", led, 16'h0000);
        check("rst_snz_flag", {15'd0, snoozing}, 16'd0);
        reset = 1'b0;

        // Randomized stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 499) == 0);
            sec_tick = ($urandom_range(0, 5) == 0);
            dismiss  = ($urandom_range(0, 49) == 0);
            snooze   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 59) == 0) alarm_enable = ~alarm_enable;
            if ($urandom_range(0, 199) == 0) begin
                alarm_hours = 5'($urandom_range(0, 31));
                alarm_mins  = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    hours_value = {1'b0, alarm_hours};
                    mins_value  = alarm_mins;
                end else begin
                    hours_value = 6'($urandom_range(0, 31));
                    mins_value  = 6'($urandom_range(0, 63));
                end
            end
            tick();
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
